obstacle_field: RTL and testbench



---
 rtl/obstacle_field.sv | 212 +++++++++++++++++++++
 tb/tb_obstacle_field.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_field.sv
// obstacle_field: scrolling multi-column obstacle engine with LFSR gap spawning, collision and scoring.
// Outputs registered, one frame_clk latency; no backpressure. OBSTACLE_FLIP_EN adds per-column gravity flip.
module obstacle_field #(
   parameter int          NUM_COLS   = 4,
   parameter int          X_W        = 11,
   parameter int          SPAWN_X    = 640,
   parameter int          PLAYER_X   = 210,
   parameter int          SPEED      = 5,
   parameter int          SPACING    = 160,
   parameter int          HALF_W     = 4,
   parameter int          GAP_HALF_V = 90,
   parameter int          GAP_MIN    = 120,
   parameter int          GAP_MAX    = 360,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                    frame_clk,
   input  logic                    Reset,
   input  logic                    start,
   input  logic [9:0]              player_y,
   input  logic [9:0]              player_size,
   output logic [NUM_COLS*X_W-1:0] col_x,
   output logic [NUM_COLS*10-1:0]  col_gap_y,
   output logic [NUM_COLS-1:0]     col_active,
   output logic [NUM_COLS-1:0]     col_flip,
   output logic                    collide,
   output logic                    pass_pulse,
   output logic [15:0]             score,
   output logic                    gravity_flip,
   output logic [1:0]              game_state
);
   localparam int XW1     = X_W + 1;
   localparam int IDX_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int GAP_RNG = GAP_MAX - GAP_MIN + 1;
   localparam logic [XW1-1:0] PX    = XW1'(PLAYER_X);
   localparam logic [XW1-1:0] SPD   = XW1'(SPEED);
   localparam logic [XW1-1:0] SPC   = XW1'(SPACING);
   localparam logic [XW1-1:0] HW    = XW1'(HALF_W);
   localparam logic [XW1-1:0] GHV   = XW1'(GAP_HALF_V);
   localparam logic [X_W-1:0] SPAWN = X_W'(SPAWN_X);

   typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_HIT = 2'b10} state_t;

   state_t              state_q;
   logic [X_W-1:0]      x_q   [NUM_COLS];
   logic [9:0]          gap_q [NUM_COLS];
   logic [NUM_COLS-1:0] act_q;
   logic [XW1-1:0]      cnt_q;
   logic [15:0]         lfsr_q;
   logic [15:0]         score_q;
   logic                collide_q;
   logic                pass_q;

   logic [NUM_COLS-1:0] hit_vec;
   logic [NUM_COLS-1:0] pass_vec;
   logic [NUM_COLS-1:0] retire_vec;
   logic [15:0]         lfsr_nxt;
   logic [15:0]         score_nxt;
   logic [9:0]          gap_new;
   logic                any_free;
   logic                spawn_due;
   logic                run_go;
   logic                spawn_fire;
   logic [IDX_W-1:0]    spawn_idx;
   logic [IDX_W-1:0]    spawn_slot;

   // All geometry is widened to X_W+1 bits and rearranged as sums so nothing underflows.
   always_comb begin
      logic [XW1-1:0] xe;
      logic [XW1-1:0] dx;
      logic [XW1-1:0] ps;
      logic [XW1-1:0] edge_sum;
      logic           in_gap;
      logic [16:0]    pass_n;
      logic [16:0]    score_sum;
      xe         = '0;
      dx         = '0;
      edge_sum   = '0;
      in_gap     = 1'b0;
      pass_n     = '0;
      ps         = XW1'(player_size);
      hit_vec    = '0;
      pass_vec   = '0;
      retire_vec = '0;
      any_free   = 1'b0;
      spawn_idx  = '0;
      for (int i = NUM_COLS - 1; i >= 0; i--) begin
         xe       = XW1'(x_q[i]);
         dx       = (xe >= PX) ? (xe - PX) : (PX - xe);
         in_gap   = (XW1'(player_y) + GHV >= XW1'(gap_q[i]) + ps) &&
                    (XW1'(player_y) + ps <= XW1'(gap_q[i]) + GHV);
         edge_sum = xe + HW + ps;
         hit_vec[i]    = act_q[i] && (dx <= HW + ps) && !in_gap;
         retire_vec[i] = act_q[i] && (xe <= SPD);
         pass_vec[i]   = act_q[i] && (edge_sum >= PX) && (edge_sum < PX + SPD);
         if (!act_q[i] || retire_vec[i]) begin
            any_free  = 1'b1;
            spawn_idx = IDX_W'(i);
         end
         pass_n = pass_n + 17'(pass_vec[i]);
      end
      score_sum  = {1'b0, score_q} + pass_n;
      score_nxt  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      spawn_due  = (cnt_q + SPD >= SPC);
      run_go     = (state_q == S_RUN) && !(|hit_vec);
      spawn_fire = ((state_q == S_IDLE) && start) || (run_go && spawn_due && any_free);
      spawn_slot = (state_q == S_IDLE) ? '0 : spawn_idx;
      lfsr_nxt   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      gap_new    = 10'(GAP_MIN + (int'(lfsr_q[8:0]) % GAP_RNG));
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         act_q     <= '0;
         cnt_q     <= '0;
         lfsr_q    <= LFSR_SEED;
         score_q   <= '0;
         collide_q <= 1'b0;
         pass_q    <= 1'b0;
         for (int i = 0; i < NUM_COLS; i++) begin
            x_q[i]   <= SPAWN;
            gap_q[i] <= '0;
         end
      end else begin
         lfsr_q <= lfsr_nxt;
         pass_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) state_q <= S_RUN;
            end
            S_RUN: begin
               if (|hit_vec) begin
                  state_q   <= S_HIT;
                  collide_q <= 1'b1;
               end else begin
                  for (int i = 0; i < NUM_COLS; i++) begin
                     if (retire_vec[i]) begin
                        act_q[i] <= 1'b0;
                        x_q[i]   <= SPAWN;
                     end else if (act_q[i]) begin
                        x_q[i] <= x_q[i] - X_W'(SPEED);
                     end
                  end
                  // A due spawn with no free slot leaves the counter parked until one frees.
                  if (!spawn_due) cnt_q <= cnt_q + SPD;
                  if (|pass_vec) begin
                     pass_q  <= 1'b1;
                     score_q <= score_nxt;
                  end
               end
            end
            S_HIT: begin
               if (start) begin
                  state_q   <= S_IDLE;
                  collide_q <= 1'b0;
                  score_q   <= '0;
                  act_q     <= '0;
                  for (int i = 0; i < NUM_COLS; i++) x_q[i] <= SPAWN;
               end
            end
            default: state_q <= S_IDLE;
         endcase
         // Placed last so a spawn overrides a retire of the same slot on the same edge.
         if (spawn_fire) begin
            act_q[spawn_slot] <= 1'b1;
            x_q[spawn_slot]   <= SPAWN;
            gap_q[spawn_slot] <= gap_new;
            cnt_q             <= '0;
         end
      end
   end

`ifdef OBSTACLE_FLIP_EN
   logic [NUM_COLS-1:0] flip_q;
   logic                gflip_q;

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         flip_q  <= '0;
         gflip_q <= 1'b0;
      end else begin
         if (spawn_fire) flip_q[spawn_slot] <= lfsr_q[15];
         if (run_go)
            gflip_q <= gflip_q ^ (^(pass_vec & flip_q));
         else if ((state_q == S_HIT) && start)
            gflip_q <= 1'b0;
      end
   end

   assign col_flip     = flip_q;
   assign gravity_flip = gflip_q;
`else
   assign col_flip     = '0;
   assign gravity_flip = 1'b0;
`endif

   always_comb begin
      col_x     = '0;
      col_gap_y = '0;
      for (int i = 0; i < NUM_COLS; i++) begin
         col_x[i*X_W +: X_W]  = x_q[i];
         col_gap_y[i*10 +: 10] = gap_q[i];
      end
   end

   assign col_active = act_q;
   assign collide    = collide_q;
   assign pass_pulse = pass_q;
   assign score      = score_q;
   assign game_state = state_q;

endmodule

// File: tb/tb_obstacle_field.sv
// Bench for obstacle_field: fixed-gap configuration with three slots so spawn deferral is exercised.
module tb_obstacle_field;
   localparam int NC      = 3;
   localparam int XW      = 11;
   localparam int SPAWN_X = 640;
   localparam int RUN_LEN = 400;
`ifdef OBSTACLE_FLIP_EN
   localparam bit FLIP = 1'b1;
`else
   localparam bit FLIP = 1'b0;
`endif

   logic             frame_clk = 1'b0;
   logic             Reset = 1'b1;
   logic             start = 1'b0;
   logic [9:0]       player_y = 10'd240;
   logic [9:0]       player_size = 10'd8;
   logic [NC*XW-1:0] col_x;
   logic [NC*10-1:0] col_gap_y;
   logic [NC-1:0]    col_active;
   logic [NC-1:0]    col_flip;
   logic             collide;
   logic             pass_pulse;
   logic [15:0]      score;
   logic             gravity_flip;
   logic [1:0]       game_state;

   int checks = 0;
   int errors = 0;
   int sp_e_q[$];
   int sp_s_q[$];
   int pass_e_q[$];

   always #5 frame_clk = ~frame_clk;

   obstacle_field #(
      .NUM_COLS(NC), .X_W(XW), .GAP_MIN(240), .GAP_MAX(240)
   ) dut (
      .frame_clk(frame_clk), .Reset(Reset), .start(start),
      .player_y(player_y), .player_size(player_size),
      .col_x(col_x), .col_gap_y(col_gap_y), .col_active(col_active), .col_flip(col_flip),
      .collide(collide), .pass_pulse(pass_pulse), .score(score),
      .gravity_flip(gravity_flip), .game_state(game_state)
   );

   task automatic step();
      @(posedge frame_clk);
      #1;
   endtask

   function automatic logic [XW-1:0] xof(int i);
      return col_x[i*XW +: XW];
   endfunction

   function automatic logic [15:0] lfsr_adv(logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   task automatic do_reset();
      Reset = 1'b1;
      start = 1'b0;
      step();
      step();
      Reset = 1'b0;
   endtask

   task automatic check_reset_values(string tag);
      checks++;
      if (game_state !== 2'b00 || col_active !== '0 || score !== 16'd0 || collide !== 1'b0 ||
          pass_pulse !== 1'b0 || gravity_flip !== 1'b0 || col_flip !== '0 || col_gap_y !== '0) begin
         errors++;
         $display("FAIL %s_outputs got st=%0d act=%b score=%0d col=%b pp=%b gf=%b cf=%b gap=%h want all zero",
                  tag, game_state, col_active, score, collide, pass_pulse, gravity_flip, col_flip, col_gap_y);
      end
      for (int i = 0; i < NC; i++) begin
         checks++;
         if (xof(i) !== XW'(SPAWN_X)) begin
            errors++;
            $display("FAIL %s_x%0d got %0d want %0d", tag, i, xof(i), SPAWN_X);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      check_reset_values("reset");
   endtask

   task automatic test_start_pass();
      player_y = 10'd240;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (game_state !== 2'b01 || col_active !== 3'b001 || xof(0) !== 11'd640 || col_gap_y[9:0] !== 10'd240) begin
         errors++;
         $display("FAIL start_spawn got st=%0d act=%b x0=%0d gap0=%0d want 1 001 640 240",
                  game_state, col_active, xof(0), col_gap_y[9:0]);
      end
      step();
      checks++;
      if (xof(0) !== 11'd635) begin
         errors++;
         $display("FAIL start_move got %0d want 635", xof(0));
      end
      for (int k = 2; k <= 95; k++) begin
         step();
         checks++;
         if (pass_pulse !== (k == 89) || collide !== 1'b0) begin
            errors++;
            $display("FAIL pass_pulse edge %0d got pp=%b col=%b want pp=%b col=0", k, pass_pulse, collide, (k == 89));
         end
         if (k == 89) begin
            checks++;
            if (xof(0) !== 11'd195) begin
               errors++;
               $display("FAIL pass_x got %0d want 195", xof(0));
            end
         end
      end
      checks++;
      if (score !== 16'd1) begin
         errors++;
         $display("FAIL pass_score got %0d want 1", score);
      end
   endtask

   task automatic test_collision();
      int k;
      do_reset();
      player_y = 10'd100;
      start = 1'b1;
      step();
      start = 1'b0;
      k = 0;
      while (game_state !== 2'b10 && k < 200) begin
         step();
         k++;
      end
      checks++;
      if (k !== 85 || xof(0) !== 11'd220 || collide !== 1'b1 || score !== 16'd0) begin
         errors++;
         $display("FAIL hit_entry got edge=%0d x0=%0d col=%b score=%0d want 85 220 1 0", k, xof(0), collide, score);
      end
      for (int j = 0; j < 5; j++) step();
      checks++;
      if (xof(0) !== 11'd220 || game_state !== 2'b10 || collide !== 1'b1) begin
         errors++;
         $display("FAIL hit_frozen got x0=%0d st=%0d col=%b want 220 2 1", xof(0), game_state, collide);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (game_state !== 2'b00 || col_active !== '0 || score !== 16'd0 || collide !== 1'b0 || xof(0) !== 11'd640) begin
         errors++;
         $display("FAIL hit_exit got st=%0d act=%b score=%0d col=%b x0=%0d want 0 000 0 0 640",
                  game_state, col_active, score, collide, xof(0));
      end
      player_y = 10'd240;
   endtask

   task automatic test_long_run();
      int e;
      int s;
      do_reset();
      player_y = 10'd240;
      sp_e_q.delete();
      sp_s_q.delete();
      pass_e_q.delete();
      // Three slots, 128-edge lifetime, 32-edge spacing: the fourth spawn of each period waits for a retire.
      for (int n = 0; n < 12; n++) begin
         e = 128 * (n / 3) + 32 * (n % 3);
         if (e <= RUN_LEN) begin
            sp_e_q.push_back(e);
            sp_s_q.push_back(n % 3);
         end
         if (e + 89 <= RUN_LEN) pass_e_q.push_back(e + 89);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k <= RUN_LEN; k++) begin
         if (k > 0) step();
         for (int i = 0; i < NC; i++) begin
            if (col_active[i] && xof(i) == XW'(SPAWN_X)) begin
               checks++;
               if (sp_e_q.size() == 0) begin
                  errors++;
                  $display("FAIL spawn_extra got slot %0d at edge %0d want no spawn", i, k);
               end else begin
                  e = sp_e_q.pop_front();
                  s = sp_s_q.pop_front();
                  if (k !== e || i !== s) begin
                     errors++;
                     $display("FAIL spawn_event got slot %0d edge %0d want slot %0d edge %0d", i, k, s, e);
                  end
               end
            end
         end
         if (pass_pulse) begin
            checks++;
            if (pass_e_q.size() == 0) begin
               errors++;
               $display("FAIL pass_extra got pulse at edge %0d want none", k);
            end else begin
               e = pass_e_q.pop_front();
               if (k !== e) begin
                  errors++;
                  $display("FAIL pass_event got edge %0d want edge %0d", k, e);
               end
            end
         end
         checks++;
         if (collide !== 1'b0) begin
            errors++;
            $display("FAIL long_collide got 1 at edge %0d want 0", k);
         end
      end
      checks++;
      if (sp_e_q.size() !== 0 || pass_e_q.size() !== 0) begin
         errors++;
         $display("FAIL long_missing got %0d spawns %0d passes outstanding want 0 0", sp_e_q.size(), pass_e_q.size());
      end
      checks++;
      if (score !== 16'd8) begin
         errors++;
         $display("FAIL long_score got %0d want 8", score);
      end
   endtask

   task automatic test_flip_and_reset();
      logic [15:0] lf;
      do_reset();
      player_y = 10'd240;
      lf = 16'hACE1;
      for (int w = 0; w < 64 && !lf[15]; w++) begin
         step();
         lf = lfsr_adv(lf);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (col_flip[0] !== FLIP || gravity_flip !== 1'b0) begin
         errors++;
         $display("FAIL flip_spawn got cf0=%b gf=%b want %b 0", col_flip[0], gravity_flip, FLIP);
      end
      for (int k = 1; k <= 89; k++) step();
      checks++;
      if (pass_pulse !== 1'b1 || gravity_flip !== FLIP) begin
         errors++;
         $display("FAIL flip_pass got pp=%b gf=%b want 1 %b", pass_pulse, gravity_flip, FLIP);
      end
      Reset = 1'b1;
      step();
      check_reset_values("midrun_reset");
      Reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout got no finish want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_start_pass();
      test_collision();
      test_long_run();
      test_flip_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
